// File: rtl/gb_cpu_fetch_decode_queue.sv
// Prefetch byte queue plus instruction-assembly FSM between the memory bus and the CPU control unit.
// Define GB_CPU_ILLEGAL_OP_EN to add the instr_illegal output flagging unused opcodes.
module gb_cpu_fetch_decode_queue #(
  parameter int QUEUE_DEPTH = 4,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr,
  output logic              fetch_req,
  output logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_ack,
  input  logic [7:0]        fetch_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [7:0]        instr_opcode,
  output logic              instr_cb,
  output logic [15:0]       instr_imm,
  output logic [1:0]        instr_len,
  output logic [ADDR_W-1:0] instr_pc
`ifdef GB_CPU_ILLEGAL_OP_EN
  ,
  output logic              instr_illegal
`endif
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    READ_OPCODE,
    READ_CB_OPCODE,
    READ_R8,
    READ_R16_BYTE0,
    READ_R16_BYTE1
  } decoder_state_t;

  function automatic logic is_imm8(input logic [7:0] op);
    logic r;
    if ((op[7:6] == 2'b00 || op[7:6] == 2'b11) && op[2:0] == 3'b110) begin
      r = 1'b1;
    end else begin
      case (op)
        8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
        8'hE0, 8'hE8, 8'hF0, 8'hF8: r = 1'b1;
        default:                    r = 1'b0;
      endcase
    end
    return r;
  endfunction

  function automatic logic is_imm16(input logic [7:0] op);
    logic r;
    if (op[7:6] == 2'b00 && op[3:0] == 4'b0001) begin
      r = 1'b1;
    end else if (op[7:5] == 3'b110 && (op[2:0] == 3'b010 || op[2:0] == 3'b100)) begin
      r = 1'b1;
    end else begin
      case (op)
        8'h08, 8'hC3, 8'hCD, 8'hEA, 8'hFA: r = 1'b1;
        default:                           r = 1'b0;
      endcase
    end
    return r;
  endfunction

`ifdef GB_CPU_ILLEGAL_OP_EN
  function automatic logic is_illegal(input logic [7:0] op);
    logic r;
    case (op)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: r = 1'b1;
      default:                           r = 1'b0;
    endcase
    return r;
  endfunction
  logic emit_ill_s, illegal_q, illegal_d;
`endif

  decoder_state_t    state_q, state_d;
  logic [7:0]        mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              fetch_req_q, fetch_req_d, stale_q, stale_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d, fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] dec_pc_q, dec_pc_d, start_pc_q, start_pc_d;
  logic [7:0]        op_q, op_d, lo_q, lo_d;
  logic              instr_valid_q, instr_valid_d, instr_cb_q, instr_cb_d;
  logic [7:0]        instr_opcode_q, instr_opcode_d;
  logic [15:0]       instr_imm_q, instr_imm_d;
  logic [1:0]        instr_len_q, instr_len_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              push_s, pop_s, out_free_s, emit_s, emit_cb_s;
  logic [7:0]        byte_s, emit_op_s;
  logic [15:0]       emit_imm_s;
  logic [1:0]        emit_len_s;
  logic [ADDR_W-1:0] emit_pc_s;

  // Next-state logic: fetch control, queue bookkeeping, assembly FSM and flush.
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    fetch_req_d    = fetch_req_q;
    fetch_pc_d     = fetch_pc_q;
    stale_d        = stale_q;
    dec_pc_d       = dec_pc_q;
    start_pc_d     = start_pc_q;
    op_d           = op_q;
    lo_d           = lo_q;
    instr_valid_d  = instr_valid_q;
    instr_opcode_d = instr_opcode_q;
    instr_cb_d     = instr_cb_q;
    instr_imm_d    = instr_imm_q;
    instr_len_d    = instr_len_q;
    instr_pc_d     = instr_pc_q;
    push_s         = 1'b0;
    pop_s          = 1'b0;
    emit_s         = 1'b0;
    emit_op_s      = 8'h00;
    emit_cb_s      = 1'b0;
    emit_imm_s     = 16'h0000;
    emit_len_s     = 2'd1;
    emit_pc_s      = dec_pc_q;
`ifdef GB_CPU_ILLEGAL_OP_EN
    emit_ill_s     = 1'b0;
    illegal_d      = illegal_q;
`endif
    byte_s         = mem_q[rd_ptr_q];
    out_free_s     = !instr_valid_q || instr_ready;

    // Only one read is ever outstanding, so the queue count alone bounds occupancy.
    if (fetch_req_q) begin
      if (fetch_ack) begin
        fetch_req_d = 1'b0;
        stale_d     = 1'b0;
        push_s      = !stale_q && !pc_load;
        fetch_pc_d  = stale_q ? fetch_pc_q : fetch_pc_q + PC_ONE;
      end else begin
        fetch_req_d = 1'b1;
      end
    end else begin
      fetch_req_d = !pc_load && (count_q < DEPTH_C);
    end

    if (!pc_load && count_q != CNT_ZERO && out_free_s) begin
      pop_s    = 1'b1;
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      dec_pc_d = dec_pc_q + PC_ONE;
      case (state_q)
        READ_OPCODE: begin
          start_pc_d = dec_pc_q;
          op_d       = byte_s;
          if (byte_s == 8'hCB) begin
            state_d = READ_CB_OPCODE;
          end
`ifdef GB_CPU_ILLEGAL_OP_EN
          else if (is_illegal(byte_s)) begin
            emit_s     = 1'b1;
            emit_op_s  = byte_s;
            emit_ill_s = 1'b1;
          end
`endif
          else if (is_imm16(byte_s)) begin
            state_d = READ_R16_BYTE0;
          end else if (is_imm8(byte_s)) begin
            state_d = READ_R8;
          end else begin
            emit_s    = 1'b1;
            emit_op_s = byte_s;
          end
        end
        READ_CB_OPCODE: begin
          emit_s     = 1'b1;
          emit_op_s  = byte_s;
          emit_cb_s  = 1'b1;
          emit_len_s = 2'd2;
          emit_pc_s  = start_pc_q;
          state_d    = READ_OPCODE;
        end
        READ_R8: begin
          emit_s     = 1'b1;
          emit_op_s  = op_q;
          emit_imm_s = {8'h00, byte_s};
          emit_len_s = 2'd2;
          emit_pc_s  = start_pc_q;
          state_d    = READ_OPCODE;
        end
        READ_R16_BYTE0: begin
          lo_d    = byte_s;
          state_d = READ_R16_BYTE1;
        end
        READ_R16_BYTE1: begin
          emit_s     = 1'b1;
          emit_op_s  = op_q;
          emit_imm_s = {byte_s, lo_q};
          emit_len_s = 2'd3;
          emit_pc_s  = start_pc_q;
          state_d    = READ_OPCODE;
        end
        default: begin
          state_d = READ_OPCODE;
        end
      endcase
    end else begin
      pop_s = 1'b0;
    end

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (emit_s) begin
      instr_valid_d  = 1'b1;
      instr_opcode_d = emit_op_s;
      instr_cb_d     = emit_cb_s;
      instr_imm_d    = emit_imm_s;
      instr_len_d    = emit_len_s;
      instr_pc_d     = emit_pc_s;
`ifdef GB_CPU_ILLEGAL_OP_EN
      illegal_d      = emit_ill_s;
`endif
    end else if (instr_valid_q && instr_ready) begin
      instr_valid_d = 1'b0;
`ifdef GB_CPU_ILLEGAL_OP_EN
      illegal_d     = 1'b0;
`endif
    end else begin
      instr_valid_d = instr_valid_q;
    end

    // Flush: an in-flight read keeps its address but its data is marked stale.
    if (pc_load) begin
      count_d       = CNT_ZERO;
      wr_ptr_d      = PTR_ZERO;
      rd_ptr_d      = PTR_ZERO;
      state_d       = READ_OPCODE;
      instr_valid_d = 1'b0;
      dec_pc_d      = pc_load_addr;
      fetch_pc_d    = pc_load_addr;
      fetch_req_d   = fetch_req_q && !fetch_ack;
      stale_d       = fetch_req_q && !fetch_ack;
`ifdef GB_CPU_ILLEGAL_OP_EN
      illegal_d     = 1'b0;
`endif
    end else begin
      dec_pc_d = dec_pc_d;
    end

    fetch_addr_d = (fetch_req_q && fetch_req_d) ? fetch_addr_q : fetch_pc_d;
  end

  // Byte storage for the prefetch queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= fetch_data;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= READ_OPCODE;
      wr_ptr_q       <= PTR_ZERO;
      rd_ptr_q       <= PTR_ZERO;
      count_q        <= CNT_ZERO;
      fetch_req_q    <= 1'b0;
      stale_q        <= 1'b0;
      fetch_addr_q   <= PC_ZERO;
      fetch_pc_q     <= PC_ZERO;
      dec_pc_q       <= PC_ZERO;
      start_pc_q     <= PC_ZERO;
      op_q           <= 8'h00;
      lo_q           <= 8'h00;
      instr_valid_q  <= 1'b0;
      instr_opcode_q <= 8'h00;
      instr_cb_q     <= 1'b0;
      instr_imm_q    <= 16'h0000;
      instr_len_q    <= 2'd0;
      instr_pc_q     <= PC_ZERO;
`ifdef GB_CPU_ILLEGAL_OP_EN
      illegal_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      fetch_req_q    <= fetch_req_d;
      stale_q        <= stale_d;
      fetch_addr_q   <= fetch_addr_d;
      fetch_pc_q     <= fetch_pc_d;
      dec_pc_q       <= dec_pc_d;
      start_pc_q     <= start_pc_d;
      op_q           <= op_d;
      lo_q           <= lo_d;
      instr_valid_q  <= instr_valid_d;
      instr_opcode_q <= instr_opcode_d;
      instr_cb_q     <= instr_cb_d;
      instr_imm_q    <= instr_imm_d;
      instr_len_q    <= instr_len_d;
      instr_pc_q     <= instr_pc_d;
`ifdef GB_CPU_ILLEGAL_OP_EN
      illegal_q      <= illegal_d;
`endif
    end
  end

  assign fetch_req    = fetch_req_q;
  assign fetch_addr   = fetch_addr_q;
  assign instr_valid  = instr_valid_q;
  assign instr_opcode = instr_opcode_q;
  assign instr_cb     = instr_cb_q;
  assign instr_imm    = instr_imm_q;
  assign instr_len    = instr_len_q;
  assign instr_pc     = instr_pc_q;
`ifdef GB_CPU_ILLEGAL_OP_EN
  assign instr_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_gb_cpu_fetch_decode_queue.sv
// Directed bench: memory model answers fetches, scoreboard of expected instructions checked on transfer.
module tb_gb_cpu_fetch_decode_queue;

  logic        clk;
  logic        rst_n;
  logic        pc_load;
  logic [15:0] pc_load_addr;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ack;
  logic [7:0]  fetch_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic        instr_cb;
  logic [15:0] instr_imm;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;
`ifdef GB_CPU_ILLEGAL_OP_EN
  logic        instr_illegal;
`endif

  typedef struct packed {
    logic [7:0]  op;
    logic        cb;
    logic [15:0] imm;
    logic [1:0]  len;
    logic [15:0] pc;
    logic        ill;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mem [0:65535];
  bit         mem_stall;
  bit         ready_en;
  int         tests;
  int         fails;

  gb_cpu_fetch_decode_queue #(.QUEUE_DEPTH(4), .ADDR_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_ack    (fetch_ack),
    .fetch_data   (fetch_data),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_cb     (instr_cb),
    .instr_imm    (instr_imm),
    .instr_len    (instr_len),
    .instr_pc     (instr_pc)
`ifdef GB_CPU_ILLEGAL_OP_EN
    ,
    .instr_illegal(instr_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: answers a pending request at the next falling edge unless stalled.
  initial begin
    fetch_ack  = 1'b0;
    fetch_data = 8'h00;
    forever begin
      @(negedge clk);
      if (fetch_req && !fetch_ack && !mem_stall) begin
        fetch_ack  = 1'b1;
        fetch_data = mem[fetch_addr];
      end else begin
        fetch_ack = 1'b0;
      end
    end
  end

  // Consumer: ready only while expectations are queued; each transfer is checked.
  initial begin
    exp_t exp_v;
    exp_t obs_v;
    instr_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_en && sb.size() > 0) begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          exp_v = sb.pop_front();
          obs_v.op  = instr_opcode;
          obs_v.cb  = instr_cb;
          obs_v.imm = instr_imm;
          obs_v.len = instr_len;
          obs_v.pc  = instr_pc;
`ifdef GB_CPU_ILLEGAL_OP_EN
          obs_v.ill = instr_illegal;
`else
          obs_v.ill = 1'b0;
`endif
          tests++;
          assert (obs_v === exp_v) else begin
            fails++;
            $error("FAIL instr@%h: observed op=%h cb=%b imm=%h len=%0d pc=%h ill=%b expected op=%h cb=%b imm=%h len=%0d pc=%h ill=%b",
                   exp_v.pc, obs_v.op, obs_v.cb, obs_v.imm, obs_v.len, obs_v.pc, obs_v.ill,
                   exp_v.op, exp_v.cb, exp_v.imm, exp_v.len, exp_v.pc, exp_v.ill);
          end
        end
      end else begin
        instr_ready = 1'b0;
      end
    end
  end

  function automatic void exp_push(input logic [7:0] op, input logic cb, input logic [15:0] imm,
                                   input logic [1:0] len, input logic [15:0] pc, input logic ill);
    exp_t e;
    e.op  = op;
    e.cb  = cb;
    e.imm = imm;
    e.len = len;
    e.pc  = pc;
`ifdef GB_CPU_ILLEGAL_OP_EN
    e.ill = ill;
`else
    e.ill = 1'b0 & ill;
`endif
    sb.push_back(e);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] a);
    @(negedge clk);
    pc_load      = 1'b1;
    pc_load_addr = a;
    @(negedge clk);
    pc_load      = 1'b0;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL %s timeout: observed %0d pending expected 0", tag, sb.size());
    end
    sb.delete();
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    rst_n        = 1'b0;
    pc_load      = 1'b0;
    pc_load_addr = 16'h0000;
    mem_stall    = 1'b0;
    ready_en     = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_fetch_req",  {31'd0, fetch_req},    32'd0);
    chk("rst_fetch_addr", {16'd0, fetch_addr},   32'd0);
    chk("rst_valid",      {31'd0, instr_valid},  32'd0);
    chk("rst_opcode",     {24'd0, instr_opcode}, 32'd0);
    chk("rst_imm_len",    {14'd0, instr_imm, instr_len}, 32'd0);
    chk("rst_pc",         {16'd0, instr_pc},     32'd0);

    // NOP stream from address 0
    for (int i = 0; i < 6; i++) exp_push(8'h00, 1'b0, 16'h0000, 2'd1, 16'(i), 1'b0);
    ready_en = 1'b1;
    rst_n    = 1'b1;
    wait_empty("nop_stream");

    // imm16, CB-prefixed, imm8, plain
    mem[16'h0100] = 8'h01; mem[16'h0101] = 8'h34; mem[16'h0102] = 8'h12;
    mem[16'h0103] = 8'hCB; mem[16'h0104] = 8'h37;
    mem[16'h0105] = 8'h3E; mem[16'h0106] = 8'h5A;
    do_load(16'h0100);
    exp_push(8'h01, 1'b0, 16'h1234, 2'd3, 16'h0100, 1'b0);
    exp_push(8'h37, 1'b1, 16'h0000, 2'd2, 16'h0103, 1'b0);
    exp_push(8'h3E, 1'b0, 16'h005A, 2'd2, 16'h0105, 1'b0);
    exp_push(8'h00, 1'b0, 16'h0000, 2'd1, 16'h0107, 1'b0);
    wait_empty("mixed_lengths");

    // Backpressure: queue fills, fetch stops, output held
    ready_en = 1'b0;
    mem[16'h0201] = 8'h3E; mem[16'h0202] = 8'h11;
    do_load(16'h0200);
    repeat (20) @(negedge clk);
    chk("bp_fetch_req",  {31'd0, fetch_req},    32'd0);
    chk("bp_fetch_addr", {16'd0, fetch_addr},   32'h0205);
    chk("bp_valid",      {31'd0, instr_valid},  32'd1);
    chk("bp_opcode",     {24'd0, instr_opcode}, 32'h00);
    repeat (5) @(negedge clk);
    chk("bp_pc_stable",  {16'd0, instr_pc},     32'h0200);
    chk("bp_req_stays0", {31'd0, fetch_req},    32'd0);
    exp_push(8'h00, 1'b0, 16'h0000, 2'd1, 16'h0200, 1'b0);
    exp_push(8'h3E, 1'b0, 16'h0011, 2'd2, 16'h0201, 1'b0);
    exp_push(8'h00, 1'b0, 16'h0000, 2'd1, 16'h0203, 1'b0);
    ready_en = 1'b1;
    wait_empty("backpressure");

    // Flush while a request is outstanding
    repeat (20) @(negedge clk);
    chk("idle_before_stall", {31'd0, fetch_req}, 32'd0);
    mem_stall = 1'b1;
    mem[16'h0300] = 8'hC3;
    mem[16'h2000] = 8'h06; mem[16'h2001] = 8'h77;
    do_load(16'h0300);
    @(negedge clk);
    chk("pend_req",  {31'd0, fetch_req},  32'd1);
    chk("pend_addr", {16'd0, fetch_addr}, 32'h0300);
    do_load(16'h2000);
    chk("inflight_req",  {31'd0, fetch_req},  32'd1);
    chk("inflight_addr", {16'd0, fetch_addr}, 32'h0300);
    mem_stall = 1'b0;
    exp_push(8'h06, 1'b0, 16'h0077, 2'd2, 16'h2000, 1'b0);
    wait_empty("flush_pending");

    // Address wrap plus more opcode classes
    mem[16'hFFFF] = 8'hC3; mem[16'h0000] = 8'h00; mem[16'h0001] = 8'hC0;
    mem[16'h0003] = 8'hCD; mem[16'h0004] = 8'h34; mem[16'h0005] = 8'h12;
    mem[16'h0006] = 8'h18; mem[16'h0007] = 8'hFE;
    mem[16'h0008] = 8'hE3;
    mem[16'h0009] = 8'hFA; mem[16'h000A] = 8'h00; mem[16'h000B] = 8'hC0;
    mem[16'h000C] = 8'hCB; mem[16'h000D] = 8'h7C;
    do_load(16'hFFFF);
    exp_push(8'hC3, 1'b0, 16'hC000, 2'd3, 16'hFFFF, 1'b0);
    exp_push(8'h00, 1'b0, 16'h0000, 2'd1, 16'h0002, 1'b0);
    exp_push(8'hCD, 1'b0, 16'h1234, 2'd3, 16'h0003, 1'b0);
    exp_push(8'h18, 1'b0, 16'h00FE, 2'd2, 16'h0006, 1'b0);
    exp_push(8'hE3, 1'b0, 16'h0000, 2'd1, 16'h0008, 1'b1);
    exp_push(8'hFA, 1'b0, 16'hC000, 2'd3, 16'h0009, 1'b0);
    exp_push(8'h7C, 1'b1, 16'h0000, 2'd2, 16'h000C, 1'b0);
    wait_empty("wrap_and_classes");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
